// File: rtl/rvnova_pkg.sv
// Shared core constants for the rvnova pipeline, plus a small sizing helper
// used by the writeback arbiter modules.
package rvnova_pkg;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int NUM_WB_SRC = 2;
   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_LSU = 1;

   // Index width for an n-entry selector; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: the first requester found scanning from
// ptr upward (with wrap) wins; output is a one-hot grant plus its index.
module rr_arbiter
   import rvnova_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] scan_idx;
   logic          found;

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      scan_idx = ptr;
      for (int k = 0; k < N; k++) begin
         if (en && !found && req[scan_idx]) begin
            gnt[scan_idx] = 1'b1;
            gnt_idx       = scan_idx;
            found         = 1'b1;
         end
         scan_idx = (scan_idx == IW'(N - 1)) ? '0 : scan_idx + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between NUM_SRC writeback
// sources using round-robin arbitration; the winner is registered onto rf_*.
module regfile_wb_arbiter
   import rvnova_pkg::*;
#(
   parameter int NUM_SRC = rvnova_pkg::NUM_WB_SRC,
   parameter int XLEN    = rvnova_pkg::XLEN,
   parameter int REG_AW  = rvnova_pkg::REG_AW,
   parameter int CNT_W   = 16,
   parameter int SW      = idx_w(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wb_en,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*REG_AW-1:0] src_rd_addr,
   input  logic [NUM_SRC*XLEN-1:0]   src_data,
   output logic                      rf_we,
   output logic [REG_AW-1:0]         rf_rd_addr,
   output logic [XLEN-1:0]           rf_w_data,
   output logic [SW-1:0]             rf_wb_src,
   output logic [CNT_W-1:0]          conflict_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_rd_addr_q, rf_rd_addr_d;
   logic [XLEN-1:0]   rf_w_data_q, rf_w_data_d;
   logic [SW-1:0]     rf_wb_src_q, rf_wb_src_d;
   logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

   logic [NUM_SRC-1:0] gnt;
   logic [SW-1:0]      gnt_idx;
   logic [REG_AW-1:0]  sel_addr;
   logic [XLEN-1:0]    sel_data;
   logic               xfer;

   // Reset gates the arbiter so no handshake can complete while it is held.
   rr_arbiter #(
      .N  (NUM_SRC),
      .IW (SW)
   ) u_rr_arbiter (
      .req     (src_valid),
      .en      (wb_en & ~reset),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign src_ready = gnt;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt[i]) begin
            sel_addr = src_rd_addr[i*REG_AW +: REG_AW];
            sel_data = src_data[i*XLEN +: XLEN];
         end
      end
      xfer = |gnt;

      rr_ptr_d     = rr_ptr_q;
      rf_we_d      = 1'b0;
      rf_rd_addr_d = rf_rd_addr_q;
      rf_w_data_d  = rf_w_data_q;
      rf_wb_src_d  = rf_wb_src_q;
      if (xfer) begin
         rr_ptr_d     = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
         rf_we_d      = (sel_addr != '0);
         rf_rd_addr_d = sel_addr;
         rf_w_data_d  = sel_data;
         rf_wb_src_d  = gnt_idx;
      end

      // Conflicts only count while grants are enabled; x0 requests count too.
      conflict_cnt_d = conflict_cnt_q;
      if (wb_en && ($countones(src_valid) >= 2)) begin
         conflict_cnt_d = sat_inc(conflict_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q       <= '0;
         rf_we_q        <= 1'b0;
         rf_rd_addr_q   <= '0;
         rf_w_data_q    <= '0;
         rf_wb_src_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         rf_we_q        <= rf_we_d;
         rf_rd_addr_q   <= rf_rd_addr_d;
         rf_w_data_q    <= rf_w_data_d;
         rf_wb_src_q    <= rf_wb_src_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_rd_addr   = rf_rd_addr_q;
   assign rf_w_data    = rf_w_data_q;
   assign rf_wb_src    = rf_wb_src_q;
   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with two sources and a 4-bit
// conflict counter so saturation is reachable in a short run.
module tb_regfile_wb_arbiter;

   localparam int NUM_SRC = 2;
   localparam int XLEN    = 32;
   localparam int REG_AW  = 5;
   localparam int CNT_W   = 4;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      wb_en;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*REG_AW-1:0] src_rd_addr;
   logic [NUM_SRC*XLEN-1:0]   src_data;
   logic                      rf_we;
   logic [REG_AW-1:0]         rf_rd_addr;
   logic [XLEN-1:0]           rf_w_data;
   logic [0:0]                rf_wb_src;
   logic [CNT_W-1:0]          conflict_cnt;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(
      .NUM_SRC (NUM_SRC),
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_en        (wb_en),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_rd_addr  (src_rd_addr),
      .src_data     (src_data),
      .rf_we        (rf_we),
      .rf_rd_addr   (rf_rd_addr),
      .rf_w_data    (rf_w_data),
      .rf_wb_src    (rf_wb_src),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
      src_valid   = v;
      src_rd_addr = {a1, a0};
      src_data    = {d1, d0};
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wb_en = 1'b1;
      set_src(2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222);

      // Reset held two cycles with both sources requesting
      chk("rst_ready", src_ready, 2'b00);
      tick();
      chk("rst_ready_c1", src_ready, 2'b00);
      tick();
      chk("rst_ready_c2", src_ready, 2'b00);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_src", rf_wb_src, 1'b0);
      chk("rst_addr", rf_rd_addr, 5'd0);
      chk("rst_data", rf_w_data, 32'd0);
      chk("rst_cnt", conflict_cnt, 4'd0);
      reset = 1'b0;

      // Single source 0
      set_src(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
      chk("s0_ready", src_ready, 2'b01);
      tick();
      chk("s0_we", rf_we, 1'b1);
      chk("s0_addr", rf_rd_addr, 5'd5);
      chk("s0_data", rf_w_data, 32'hDEAD_BEEF);
      chk("s0_src", rf_wb_src, 1'b0);
      set_src(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      chk("idle_ready", src_ready, 2'b00);
      tick();
      chk("idle_we", rf_we, 1'b0);
      chk("idle_addr_hold", rf_rd_addr, 5'd5);
      chk("idle_data_hold", rf_w_data, 32'hDEAD_BEEF);

      // Single source 1 (pointer sits at 1, wraps back to 0 afterwards)
      set_src(2'b10, 5'd0, 32'h0, 5'd7, 32'hCAFE_F00D);
      chk("s1_ready", src_ready, 2'b10);
      tick();
      chk("s1_we", rf_we, 1'b1);
      chk("s1_addr", rf_rd_addr, 5'd7);
      chk("s1_data", rf_w_data, 32'hCAFE_F00D);
      chk("s1_src", rf_wb_src, 1'b1);
      chk("s1_cnt", conflict_cnt, 4'd0);

      // Contention: grants alternate 0,1,0,1
      set_src(2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ct_ready%0d", k), src_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         chk($sformatf("ct_src%0d", k), rf_wb_src, (k % 2 == 0) ? 1'b0 : 1'b1);
         chk($sformatf("ct_addr%0d", k), rf_rd_addr, (k % 2 == 0) ? 5'd1 : 5'd2);
         chk($sformatf("ct_data%0d", k), rf_w_data, (k % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
         chk($sformatf("ct_we%0d", k), rf_we, 1'b1);
      end
      chk("ct_cnt", conflict_cnt, 4'd4);

      // x0 write from source 1: consumed, no regfile write
      set_src(2'b10, 5'd0, 32'h0, 5'd0, 32'h5555_AAAA);
      chk("x0_ready", src_ready, 2'b10);
      tick();
      chk("x0_we", rf_we, 1'b0);
      chk("x0_src", rf_wb_src, 1'b1);
      chk("x0_addr", rf_rd_addr, 5'd0);
      set_src(2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1);
      chk("x0_wrap_ready", src_ready, 2'b01);
      tick();
      chk("x0_wrap_src", rf_wb_src, 1'b0);
      chk("x0_wrap_cnt", conflict_cnt, 4'd5);

      // wb_en low: nothing granted, counter frozen, pointer preserved at 1
      wb_en = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold_ready%0d", k), src_ready, 2'b00);
         tick();
         chk($sformatf("hold_we%0d", k), rf_we, 1'b0);
      end
      chk("hold_cnt", conflict_cnt, 4'd5);
      wb_en = 1'b1;
      #1;
      chk("resume_ready", src_ready, 2'b10);
      tick();
      chk("resume_src", rf_wb_src, 1'b1);
      chk("resume_we", rf_we, 1'b1);
      chk("resume_cnt", conflict_cnt, 4'd6);

      // Saturation: 21 contention cycles push 6 well past 15
      for (int k = 0; k < 21; k++) tick();
      chk("sat_cnt", conflict_cnt, 4'd15);
      chk("sat_src", rf_wb_src, 1'b0);
      chk("sat_ready_ptr1", src_ready, 2'b10);

      // Reset mid-stream: last captured transfer still visible, then cleared
      reset = 1'b1;
      #1;
      chk("mrst_ready", src_ready, 2'b00);
      chk("mrst_we_pending", rf_we, 1'b1);
      tick();
      chk("mrst_we", rf_we, 1'b0);
      chk("mrst_cnt", conflict_cnt, 4'd0);
      chk("mrst_src", rf_wb_src, 1'b0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", src_ready, 2'b01);
      tick();
      chk("post_rst_src", rf_wb_src, 1'b0);
      chk("post_rst_addr", rf_rd_addr, 5'd1);
      chk("post_rst_cnt", conflict_cnt, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
